seq_pattern_gen: RTL and testbench
==================================

Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter: the driving end for the serial sequence detectors (e.g. the Moore "101" detector on clk/rst/data_in/data_out).
- Loads a programmable pattern of up to PAT_W bits and shifts it out MSB-first, one bit per clock, on data_out.
- Supports a repeat count with a programmable idle gap between copies.
- Used as an on-chip stimulus source and as the serial source feeding detector inputs.

Parameters:
PAT_W, 8, maximum pattern length in bits
LEN_W, 4, width of pat_len; must satisfy 2^LEN_W > PAT_W
REP_W, 4, width of rep_cnt (additional copies after the first)
GAP_W, 4, width of gap_len (idle cycles between copies)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin transmission; sampled in IDLE only
pattern  in  PAT_W  bits to send; bit pat_len-1 is sent first
pat_len  in  LEN_W  number of bits per copy, 1..PAT_W
rep_cnt  in  REP_W  additional copies; total copies = rep_cnt+1
gap_len  in  GAP_W  idle cycles between copies; 0 = back-to-back
abort  in  1  synchronous cancel
data_out  out  1  serial data; 0 when not sending
out_valid  out  1  high on every cycle data_out carries a pattern bit
busy  out  1  high from the cycle after start through the last bit/gap
done  out  1  one-cycle pulse on the cycle after the final bit

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; data_out, out_valid, busy, done = 0; all counters and shadow registers cleared. Takes effect immediately, including mid-transmission; no done pulse.
- All outputs are registered.
- States:
  - IDLE: wait for start.
  - SEND: shift pattern bits.
  - GAP: insert idle cycles between copies.
  - DONE: single-cycle done pulse, then IDLE.
- IDLE -> SEND when start=1 and pat_len!=0:
  - Capture pattern, pat_len, rep_cnt and gap_len into shadow registers. Later input changes have no effect.
  - pat_len > PAT_W is clamped to PAT_W.
  - pat_len==0: start is ignored; stay in IDLE; no done.
- Latency: start sampled at edge k -> first bit on data_out with out_valid=1 after edge k+1.
- SEND:
  - bit index counts pat_len-1 down to 0; one bit per cycle.
  - After the bit-0 cycle: copies remaining > 0 and gap_len > 0 -> GAP; copies remaining > 0 and gap_len==0 -> SEND (reload index, no bubble); otherwise -> DONE.
- GAP: data_out=0, out_valid=0, busy=1 for exactly gap_len cycles, then SEND with the index reloaded.
- DONE: done=1 and busy=0 for one cycle, then IDLE. A start arriving in the DONE cycle is ignored.
- Total busy cycles = (rep_cnt+1)*pat_len + rep_cnt*gap_len.
- start while busy (SEND/GAP): ignored.
- abort=1 in SEND/GAP: next state IDLE; data_out, out_valid, busy = 0 after the next edge; no done pulse. abort has priority over start and over all transitions. abort in IDLE: no effect.
- Counter widths: bit index LEN_W; copy counter REP_W; gap counter GAP_W. No wrap-around is possible because every counter reloads from a shadow register.

Decomposition:
- Package seq_gen_pkg holds:
  - state enum (IDLE, SEND, GAP, DONE)
  - default parameter constants
  - a clamp function for pat_len
- Sub-module: one reusable loadable down-counter, seq_down_cnt (parameterised width; load, dec and zero flag). Instantiated for bit index, copies and gap.
- The FSM and the shift mux stay in seq_pattern_gen.

Test Plan:
1. pattern=8'b0000_0101, pat_len=3, rep_cnt=0, gap_len=0, start pulse -> data_out 1,0,1 with out_valid=1 for 3 cycles; done on the 4th cycle; busy high for exactly 3 cycles. When connected to the Moore 101 detector, the detector output goes high once.
2. pattern=5'b10101, pat_len=5, rep_cnt=1, gap_len=2 -> 1,0,1,0,1, two idle cycles (out_valid=0), 1,0,1,0,1, then done. busy high for 12 cycles.
3. pat_len=4, pattern=4'b1100, rep_cnt=2, gap_len=0 -> 1100 1100 1100 contiguous with out_valid held high for 12 cycles; single done pulse.
4. Start pulse during SEND, plus changes to pattern mid-send -> output stream unchanged, no restart. A start with pat_len=0 in IDLE -> no busy, no done.
5. abort asserted on the 3rd bit of an 8-bit send -> after the next edge, data_out, out_valid, busy = 0; state IDLE; done never pulses. A following start works normally.
6. rst driven low asynchronously mid-GAP (between clock edges) -> all outputs 0 immediately. After rst is released, no output until a new start.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - shared types, defaults and helpers for the serial pattern generator
package seq_gen_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Requested lengths above the pattern register width are sent as a full-width pattern.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - control/serial-output bundle of the pattern generator
// master: stimulus side (drives start/pattern/pat_len/rep_cnt/gap_len/abort)
// slave : generator side (drives data_out/out_valid/busy/done)
interface seq_pattern_gen_if
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] rep_cnt;
  logic [GAP_W-1:0] gap_len;
  logic             abort;
  logic             data_out;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, pat_len, rep_cnt, gap_len, abort,
    input  data_out, out_valid, busy, done
  );

  modport slave (
    input  start, pattern, pat_len, rep_cnt, gap_len, abort,
    output data_out, out_valid, busy, done
  );
endinterface

// File: rtl/seq_down_cnt.sv
// rtl/seq_down_cnt.sv - loadable down-counter with zero flag
// clk, rst_n : clock, asynchronous active-low reset
// load       : load load_val (wins over dec)
// dec        : decrement by one; holds at zero
// count/zero : current value and count==0 flag
module seq_down_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;

  assign zero  = (count_q == '0);
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && !zero) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - serial pattern transmitter, MSB-first, with repeat count and idle gap
// clk : clock, rising edge
// rst : asynchronous active-low reset
// bus : seq_pattern_gen_if.slave (start/pattern/pat_len/rep_cnt/gap_len/abort in,
//       data_out/out_valid/busy/done out, all outputs registered)
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  seq_pattern_gen_if.slave bus
);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             idx_load, idx_dec, idx_zero;
  logic [LEN_W-1:0] idx_val, idx_count;
  logic             rep_load, rep_dec, rep_zero;
  logic [REP_W-1:0] rep_val, rep_count;
  logic             gap_load, gap_dec, gap_zero;
  logic [GAP_W-1:0] gap_val, gap_count;

  logic [LEN_W-1:0] len_clamped;
  logic             cur_bit;

  seq_down_cnt #(.W(LEN_W)) u_idx_cnt (
    .clk(clk), .rst_n(rst), .load(idx_load), .load_val(idx_val),
    .dec(idx_dec), .count(idx_count), .zero(idx_zero)
  );

  // Holds the number of copies still to send after the current one.
  seq_down_cnt #(.W(REP_W)) u_rep_cnt (
    .clk(clk), .rst_n(rst), .load(rep_load), .load_val(rep_val),
    .dec(rep_dec), .count(rep_count), .zero(rep_zero)
  );

  // Loaded with gap-1 so the zero flag marks the final idle cycle.
  seq_down_cnt #(.W(GAP_W)) u_gap_cnt (
    .clk(clk), .rst_n(rst), .load(gap_load), .load_val(gap_val),
    .dec(gap_dec), .count(gap_count), .zero(gap_zero)
  );

  // Copy and gap progress are decided from the zero flags alone.
  logic unused_counts;
  assign unused_counts = ^{rep_count, gap_count};

  assign len_clamped = LEN_W'(clamp_len(32'(bus.pat_len), PAT_W));

  always_comb begin
    cur_bit = 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (idx_count == LEN_W'(i)) begin
        cur_bit = pattern_q[i];
      end
    end
  end

  // Outputs lag the state by one edge: the edge that leaves IDLE only loads the
  // shadows, each SEND/GAP edge registers the bit/idle cycle it represents, and
  // the DONE edge registers the done pulse.
  always_comb begin
    state_d     = state_q;
    pattern_d   = pattern_q;
    len_d       = len_q;
    gap_d       = gap_q;
    data_out_d  = 1'b0;
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    idx_load    = 1'b0;
    idx_dec     = 1'b0;
    idx_val     = len_q - LEN_W'(1);
    rep_load    = 1'b0;
    rep_dec     = 1'b0;
    rep_val     = bus.rep_cnt;
    gap_load    = 1'b0;
    gap_dec     = 1'b0;
    gap_val     = gap_q - GAP_W'(1);

    case (state_q)
      IDLE: begin
        // done_q high means this is the done-pulse cycle, where start is ignored.
        if (bus.start && (bus.pat_len != '0) && !done_q) begin
          pattern_d = bus.pattern;
          len_d     = len_clamped;
          gap_d     = bus.gap_len;
          idx_load  = 1'b1;
          idx_val   = len_clamped - LEN_W'(1);
          rep_load  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          data_out_d  = cur_bit;
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
          if (!idx_zero) begin
            idx_dec = 1'b1;
          end else if (!rep_zero) begin
            rep_dec = 1'b1;
            if (gap_q != '0) begin
              gap_load = 1'b1;
              state_d  = GAP;
            end else begin
              idx_load = 1'b1;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          if (gap_zero) begin
            idx_load = 1'b1;
            state_d  = SEND;
          end else begin
            gap_dec = 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pattern_q   <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      data_out_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - directed self-checking bench for seq_pattern_gen
module tb_seq_pattern_gen;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_pattern_gen_if bus ();

  seq_pattern_gen dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pattern;
    logic [3:0]  pat_len;
    logic [3:0]  rep_cnt;
    logic [3:0]  gap_len;
    int          n;      // expected busy cycles
    logic [31:0] dout;   // expected data_out, first cycle in bit n-1
    logic [31:0] vld;    // expected out_valid, same ordering
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " data_out"}, 32'(bus.data_out), 32'd0);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " busy"}, 32'(bus.busy), 32'd0);
    check({tag, " done"}, 32'(bus.done), 32'd0);
  endtask

  // Called at a negedge; leaves the bench at the negedge of the latency cycle.
  task automatic start_tx(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
    bus.pattern = p;
    bus.pat_len = l;
    bus.rep_cnt = r;
    bus.gap_len = g;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("latency out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  // Checks n bit/gap cycles then the done pulse; returns at the done-pulse negedge.
  task automatic expect_stream(input string tag, input int n, input logic [31:0] dout,
                               input logic [31:0] vld, input bit disturb);
    logic [31:0] dv;
    logic [31:0] vv;
    dv = dout;
    vv = vld;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, " data_out"}, 32'(bus.data_out), 32'(dv[n-1-i]));
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'(vv[n-1-i]));
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " done early"}, 32'(bus.done), 32'd0);
      if (disturb && i == 1) begin
        bus.start   = 1'b1;
        bus.pattern = 8'hFF;
        bus.pat_len = 4'd3;
      end else if (disturb && i == 2) begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, " done pulse"}, 32'(bus.done), 32'd1);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check({tag, " out_valid at done"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    vecs[0] = '{8'h05, 4'd3,  4'd0, 4'd0, 3,  32'b101,          32'b111};
    vecs[1] = '{8'h15, 4'd5,  4'd1, 4'd2, 12, 32'b101010010101, 32'b111110011111};
    vecs[2] = '{8'h0C, 4'd4,  4'd2, 4'd0, 12, 32'b110011001100, 32'b111111111111};
    vecs[3] = '{8'hA5, 4'd8,  4'd0, 4'd0, 8,  32'b10100101,     32'b11111111};
    vecs[4] = '{8'h81, 4'd12, 4'd0, 4'd0, 8,  32'b10000001,     32'b11111111};
    vecs[5] = '{8'h01, 4'd1,  4'd2, 4'd1, 5,  32'b10101,        32'b10101};

    rst         = 1'b0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.pattern = '0;
    bus.pat_len = '0;
    bus.rep_cnt = '0;
    bus.gap_len = '0;
    @(negedge clk);
    @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      start_tx(vecs[v].pattern, vecs[v].pat_len, vecs[v].rep_cnt, vecs[v].gap_len);
      expect_stream($sformatf("vec%0d", v), vecs[v].n, vecs[v].dout, vecs[v].vld, 1'b0);
      @(negedge clk);
      check("done single cycle", 32'(bus.done), 32'd0);
    end

    // start and pattern change mid-send must not disturb the stream
    start_tx(8'hA5, 4'd8, 4'd0, 4'd0);
    expect_stream("midsend", 8, 32'b10100101, 32'b11111111, 1'b1);

    // start arriving in the done-pulse cycle is ignored
    bus.pattern = 8'h05;
    bus.pat_len = 4'd3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("start in done");
    end

    // pat_len == 0 start is ignored
    start_tx(8'hFF, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("zero len");
    end

    // abort while the 3rd bit of A5 (a 1) is on data_out
    start_tx(8'hA5, 4'd8, 4'd0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("abort 3rd bit", 32'(bus.data_out), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_quiet("after abort");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_quiet("post abort");
    end
    start_tx(8'h05, 4'd3, 4'd0, 4'd0);
    expect_stream("after abort", 3, 32'b101, 32'b111, 1'b0);
    @(negedge clk);

    // asynchronous reset in the middle of the idle gap
    start_tx(8'h15, 4'd5, 4'd1, 4'd2);
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("in gap busy", 32'(bus.busy), 32'd1);
    check("in gap out_valid", 32'(bus.out_valid), 32'd0);
    #2 rst = 1'b0;
    #1 check_quiet("async reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_quiet("post reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
